// File: rtl/fma_pkg.sv
// Shared FMA datapath constants and the packed-word record used by the quantized-output packer.
// Pure declarations; no logic.
package fma_pkg;

    localparam int BW_INT = 8;
    localparam int BW_EXP = 8;
    localparam int LANES  = 4;

    typedef struct packed {
        logic [LANES*BW_INT-1:0] data;
        logic [LANES-1:0]        mask;
        logic [BW_EXP-1:0]       scale;
        logic                    last;
    } qpack_word_t;

endpackage

// File: rtl/fma_pack_fifo2.sv
// Two-entry word queue between the packer's assembly register and the writeback port.
// Latency: a pushed word is visible at head_dat the cycle after push (when queue was empty).
// Backpressure: push is ignored when full, pop is ignored when empty; the caller gates on occ.
module fma_pack_fifo2
    import fma_pkg::*;
#(
    parameter type word_t = qpack_word_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  word_t      push_dat,
    input  logic       pop,
    output logic [1:0] occ,
    output word_t      head_dat
);

    word_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  do_push;
    logic  do_pop;

    assign do_push  = push && (occ != 2'd2);
    assign do_pop   = pop  && (occ != 2'd0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fma_quant_packer.sv
// Packs per-cycle quantized integers into LANES-wide words with lane mask and lane-0 scale.
// Latency: closing element appears at out_valid one cycle later when the queue is empty.
// Backpressure: in_ready drops when the 2-entry queue is full (registered, no out_ready path).
// Optional zero-lane counter enabled by defining QPACK_ZCNT_EN.
module fma_quant_packer #(
    parameter int BW_INT = fma_pkg::BW_INT,
    parameter int BW_EXP = fma_pkg::BW_EXP,
    parameter int LANES  = fma_pkg::LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BW_INT-1:0]       quat_int,
    input  logic [BW_EXP-1:0]       scale,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*BW_INT-1:0] out_data,
    output logic [LANES-1:0]        out_mask,
    output logic [BW_EXP-1:0]       out_scale,
    output logic                    out_last,
    output logic                    scale_err
`ifdef QPACK_ZCNT_EN
    ,
    output logic [15:0]             zero_cnt
`endif
);

    localparam int CW = $clog2(LANES);

    typedef struct packed {
        logic [LANES*BW_INT-1:0] data;
        logic [LANES-1:0]        mask;
        logic [BW_EXP-1:0]       scale;
        logic                    last;
    } word_t;

    logic [CW-1:0]                cnt;
    logic [LANES-1:0][BW_INT-1:0] asm_data;
    logic [LANES-1:0][BW_INT-1:0] lanes;
    logic [LANES-1:0]             asm_mask;
    logic [BW_EXP-1:0]            lat_scale;
    logic [1:0]                   occ;
    logic                         accept;
    logic                         close;
    logic                         pop;
    word_t                        push_word;
    word_t                        head;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign close     = accept && ((cnt == CW'(LANES - 1)) || in_last);

    // The word as it would look with the current element merged in.
    always_comb begin
        lanes           = asm_data;
        lanes[cnt]      = quat_int;
        push_word.data  = lanes;
        push_word.mask  = asm_mask | (LANES'(1) << cnt);
        push_word.scale = (cnt == '0) ? scale : lat_scale;
        push_word.last  = in_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            asm_data  <= '0;
            asm_mask  <= '0;
            lat_scale <= '0;
            scale_err <= 1'b0;
        end else begin
            scale_err <= accept && (cnt != '0) && (scale != lat_scale);
            if (accept) begin
                if (cnt == '0) begin
                    lat_scale <= scale;
                end
                if (close) begin
                    cnt      <= '0;
                    asm_data <= '0;
                    asm_mask <= '0;
                end else begin
                    cnt      <= cnt + 1'b1;
                    asm_data <= lanes;
                    asm_mask <= push_word.mask;
                end
            end
        end
    end

    fma_pack_fifo2 #(
        .word_t (word_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (close),
        .push_dat (push_word),
        .pop      (pop),
        .occ      (occ),
        .head_dat (head)
    );

    assign out_data  = head.data;
    assign out_mask  = head.mask;
    assign out_scale = head.scale;
    assign out_last  = head.last;

`ifdef QPACK_ZCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= 16'h0000;
        end else if (accept && (quat_int == '0) && (zero_cnt != 16'hFFFF)) begin
            zero_cnt <= zero_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fma_quant_packer.sv
// Directed bench for fma_quant_packer: queue-level reference model checked every cycle,
// plus literal expectations on the popped words.
module tb_fma_quant_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  quat_int;
    logic [7:0]  scale;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_mask;
    logic [7:0]  out_scale;
    logic        out_last;
    logic        scale_err;
`ifdef QPACK_ZCNT_EN
    logic [15:0] zero_cnt;
`endif

    always #5 clk = ~clk;

    fma_quant_packer #(
        .BW_INT (8),
        .BW_EXP (8),
        .LANES  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quat_int  (quat_int),
        .scale     (scale),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_scale (out_scale),
        .out_last  (out_last),
        .scale_err (scale_err)
`ifdef QPACK_ZCNT_EN
        ,
        .zero_cnt  (zero_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic [7:0]  scale;
        logic        last;
    } wd_t;

    int   n_vec = 0;
    int   n_err = 0;
    wd_t  exp_q[$];
    wd_t  got_q[$];
    logic [7:0] cur_b[4];
    int   cur_n = 0;
    logic [7:0] cur_s = '0;
    bit   exp_err = 0;
    int   err_seen = 0;
    int   zexp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: word list built from accepted elements, compared every falling edge.
    always @(negedge clk) begin : model
        bit  acc;
        bit  pp;
        wd_t w;
        wd_t g;
        if (!rst_n) begin
            exp_q.delete();
            cur_n   = 0;
            exp_err = 0;
            zexp    = 0;
        end else begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() != 2);
            chk("scale_err", scale_err, exp_err);
            if (scale_err) err_seen++;
`ifdef QPACK_ZCNT_EN
            chk("zero_cnt", zero_cnt, zexp);
`endif
            if (exp_q.size() != 0) begin
                chk("head_data", out_data, exp_q[0].data);
                chk("head_mask", out_mask, exp_q[0].mask);
                chk("head_scale", out_scale, exp_q[0].scale);
                chk("head_last", out_last, exp_q[0].last);
            end
            acc = in_valid && (exp_q.size() != 2);
            pp  = (exp_q.size() != 0) && out_ready;
            if (pp) begin
                g.data = out_data; g.mask = out_mask; g.scale = out_scale; g.last = out_last;
                got_q.push_back(g);
                void'(exp_q.pop_front());
            end
            exp_err = acc && (cur_n > 0) && (scale != cur_s);
            if (acc) begin
                if (cur_n == 0) cur_s = scale;
                cur_b[cur_n] = quat_int;
                cur_n++;
                if (quat_int == 0 && zexp < 65535) zexp++;
                if (cur_n == 4 || in_last) begin
                    w.data = 32'h0;
                    for (int i = 0; i < cur_n; i++) w.data = w.data + (32'(cur_b[i]) << (8 * i));
                    w.mask  = 4'((1 << cur_n) - 1);
                    w.scale = cur_s;
                    w.last  = in_last;
                    exp_q.push_back(w);
                    cur_n = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] s, input logic l);
        int t;
        in_valid = 1'b1; quat_int = d; scale = s; in_last = l;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input int idx, input logic [31:0] d, input logic [3:0] m,
                            input logic [7:0] s, input logic l);
        if (idx < got_q.size()) begin
            chk("word_data", got_q[idx].data, d);
            chk("word_mask", got_q[idx].mask, m);
            chk("word_scale", got_q[idx].scale, s);
            chk("word_last", got_q[idx].last, l);
        end else begin
            chk("word_missing", got_q.size(), idx + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; quat_int = '0; scale = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_scale", out_scale, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_scale_err", scale_err, 0);
`ifdef QPACK_ZCNT_EN
        chk("rst_zero_cnt", zero_cnt, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate stream of two complete words.
        got_q.delete();
        for (int i = 1; i <= 8; i++) send(8'(i), 8'd5, 1'b0);
        drain();
        chk("two_words", got_q.size(), 2);
        chk_word(0, 32'h04030201, 4'hF, 8'd5, 1'b0);
        chk_word(1, 32'h08070605, 4'hF, 8'd5, 1'b0);

        // Partial word closed by in_last.
        got_q.delete();
        send(8'h11, 8'd5, 1'b0);
        send(8'h22, 8'd5, 1'b0);
        send(8'h33, 8'd5, 1'b1);
        drain();
        chk_word(0, 32'h00332211, 4'h7, 8'd5, 1'b1);

        // Single-lane word from in_last at lane 0.
        got_q.delete();
        send(8'h5A, 8'd3, 1'b1);
        drain();
        chk_word(0, 32'h0000005A, 4'h1, 8'd3, 1'b1);

        // Writeback stalled: queue fills, producer stalls, nothing lost on release.
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 12; i++) send(8'(i), 8'd9, 1'b0);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_words", got_q.size(), 3);
        chk_word(0, 32'h04030201, 4'hF, 8'd9, 1'b0);
        chk_word(1, 32'h08070605, 4'hF, 8'd9, 1'b0);
        chk_word(2, 32'h0C0B0A09, 4'hF, 8'd9, 1'b0);

        // Scale mismatch on lane 2 only.
        got_q.delete();
        err_seen = 0;
        send(8'h01, 8'd5, 1'b0);
        send(8'h02, 8'd5, 1'b0);
        send(8'h03, 8'd6, 1'b0);
        send(8'h04, 8'd5, 1'b0);
        drain();
        chk("scale_err_pulses", err_seen, 1);
        chk_word(0, 32'h04030201, 4'hF, 8'd5, 1'b0);

        // Reset with one queued word and a partial word in assembly.
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'hB0 + 8'(i), 8'd2, 1'b0);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 4; i++) send(8'hA0 + 8'(i), 8'd7, 1'b0);
        drain();
        chk("post_rst_words", got_q.size(), 1);
        chk_word(0, 32'hA4A3A2A1, 4'hF, 8'd7, 1'b0);

`ifdef QPACK_ZCNT_EN
        send(8'h00, 8'd1, 1'b0);
        send(8'h07, 8'd1, 1'b0);
        send(8'h00, 8'd1, 1'b0);
        send(8'h00, 8'd1, 1'b0);
        drain();
        chk("zero_cnt_3", zero_cnt, 16'd3);
        for (int i = 0; i < 65537; i++) send(8'h00, 8'd1, 1'b0);
        drain();
        chk("zero_cnt_sat", zero_cnt, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
